// File: rtl/mips_icache.sv
`default_nettype none
// =============================================================================
// mips_icache: direct-mapped, read-only instruction cache with line refill.
// Revision 1.0
// =============================================================================
module mips_icache #(
  parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
  parameter logic [31:0] TEXT_BYTES = 32'h0010_0000,
  parameter int          LINE_WORDS = 4,
  parameter int          NUM_LINES  = 64
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [29:0] inst_addr_PC,
  input  logic        inv_all,
  output logic [31:0] inst,
  output logic        inst_excpt,
  output logic        stall,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [15:0] miss_cnt
);

  localparam int c_off = $clog2(LINE_WORDS);
  localparam int c_idx = $clog2(NUM_LINES);
  localparam int c_tag = 30 - c_off - c_idx;
  localparam logic [31:0]      c_text_end  = TEXT_BASE + TEXT_BYTES;
  localparam logic [c_off-1:0] c_last_beat = c_off'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [c_off-1:0]     beat_q, beat_d;
  logic [15:0]          miss_cnt_q, miss_cnt_d;
  logic                 mem_req_q, mem_req_d;
  logic [29:0]          mem_addr_q, mem_addr_d;
  logic                 inv_pend_q, inv_pend_d;

  logic [31:0]      data_mem [NUM_LINES*LINE_WORDS];
  logic [c_tag-1:0] tag_mem  [NUM_LINES];

  logic [31:0]      byte_addr;
  logic             in_range;
  logic [c_off-1:0] addr_off;
  logic [c_idx-1:0] addr_idx;
  logic [c_tag-1:0] addr_tag;
  logic             hit;
  logic [c_idx-1:0] fill_idx;
  logic [c_tag-1:0] fill_tag;
  logic             fill_we;
  logic             fill_last;

  assign byte_addr = {inst_addr_PC, 2'b00};
  assign in_range  = (byte_addr >= TEXT_BASE) && (byte_addr < c_text_end);
  assign addr_off  = inst_addr_PC[c_off-1:0];
  assign addr_idx  = inst_addr_PC[c_off+c_idx-1:c_off];
  assign addr_tag  = inst_addr_PC[29:c_off+c_idx];
  assign hit       = in_range && valid_q[addr_idx] && (tag_mem[addr_idx] == addr_tag);

  // The refill target comes from the latched line address, so a PC that
  // wanders during the refill cannot redirect the write.
  assign fill_idx  = mem_addr_q[c_off+c_idx-1:c_off];
  assign fill_tag  = mem_addr_q[29:c_off+c_idx];
  assign fill_we   = (state_q == FILL) && mem_rvalid;
  assign fill_last = fill_we && (beat_q == c_last_beat);

  assign inst       = ((state_q == IDLE) && hit) ? data_mem[{addr_idx, addr_off}] : 32'h0;
  assign inst_excpt = !in_range;
  assign stall      = rst_b && ((state_q != IDLE) || (in_range && !hit));
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign miss_cnt   = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    beat_d     = beat_q;
    miss_cnt_d = miss_cnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    inv_pend_d = inv_pend_q;
    case (state_q)
      IDLE: begin
        if (inv_all) begin
          valid_d = '0;
        end
        if (in_range && !hit) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = {inst_addr_PC[29:c_off], {c_off{1'b0}}};
          miss_cnt_d = miss_cnt_q + 16'd1;
        end
      end
      REQ: begin
        if (inv_all) begin
          inv_pend_d = 1'b1;
        end
        if (mem_ack) begin
          state_d   = FILL;
          mem_req_d = 1'b0;
          beat_d    = '0;
        end
      end
      FILL: begin
        if (inv_all) begin
          inv_pend_d = 1'b1;
        end
        if (mem_rvalid) begin
          beat_d = beat_q + c_off'(1);
          if (beat_q == c_last_beat) begin
            state_d    = IDLE;
            inv_pend_d = 1'b0;
            // An invalidate seen during the refill also kills the new line.
            if (inv_pend_q || inv_all) begin
              valid_d = '0;
            end else begin
              valid_d[fill_idx] = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      beat_q     <= '0;
      miss_cnt_q <= 16'd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 30'd0;
      inv_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      beat_q     <= beat_d;
      miss_cnt_q <= miss_cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      inv_pend_q <= inv_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[{fill_idx, beat_q}] <= mem_rdata;
    end
    if (fill_last) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule
`default_nettype wire
